// File: rtl/gmii_tx_sequencer_if.sv
// Byte-stream input and GMII-side output bundle of the transmit sequencer.
// The master drives the payload stream; the slave is the sequencer itself.
interface gmii_tx_sequencer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] mac_txd;
    logic       mac_tx_en;
    logic       mac_tx_er;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, mac_txd, mac_tx_en, mac_tx_er, busy, frame_done, underrun
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, mac_txd, mac_tx_en, mac_tx_er, busy, frame_done, underrun
    );
endinterface

// File: rtl/gmii_tx_sequencer.sv
// GMII transmit framer: preamble/SFD, payload with zero padding, CRC-32 FCS,
// inter-frame gap, and clean abort when the upstream stream underruns.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line quiet, waiting for s_valid to open a frame
// PREAMBLE | emitting PREAMBLE_LEN bytes of 0x55
// SFD      | emitting 0xD5, CRC and byte count restarted
// DATA     | forwarding accepted payload bytes, folding them into CRC
// PAD      | emitting 0x00 until MIN_PAYLOAD bytes have been sent
// FCS      | emitting ~CRC, least significant byte first
// DROP     | frame aborted, discarding upstream bytes up to s_last
// IFG      | line quiet for IFG_BYTES cycles
module gmii_tx_sequencer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_BYTES    = 12
) (
    input logic                clk,
    input logic                reset,
    gmii_tx_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } state_t;

    localparam logic [16:0] MIN_CNT = 17'(MIN_PAYLOAD);

    state_t      state;
    logic [7:0]  timer;
    logic [15:0] byte_cnt;
    logic [15:0] byte_cnt_inc;
    logic [31:0] crc;
    logic        short_frame;

    function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign short_frame  = {1'b0, byte_cnt_inc} < MIN_CNT;

    assign bus.s_ready = (state == DATA) || (state == DROP);
    assign bus.busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= 8'd0;
            byte_cnt       <= 16'd0;
            crc            <= 32'hFFFFFFFF;
            bus.mac_txd    <= 8'h00;
            bus.mac_tx_en  <= 1'b0;
            bus.mac_tx_er  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.underrun   <= 1'b0;
        end else begin
            bus.mac_txd    <= 8'h00;
            bus.mac_tx_en  <= 1'b0;
            bus.mac_tx_er  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.underrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        state <= PREAMBLE;
                        timer <= 8'(PREAMBLE_LEN - 1);
                    end
                end

                PREAMBLE: begin
                    bus.mac_txd   <= 8'h55;
                    bus.mac_tx_en <= 1'b1;
                    if (timer == 8'd0) state <= SFD;
                    else               timer <= timer - 8'd1;
                end

                SFD: begin
                    bus.mac_txd   <= 8'hD5;
                    bus.mac_tx_en <= 1'b1;
                    crc           <= 32'hFFFFFFFF;
                    byte_cnt      <= 16'd0;
                    state         <= DATA;
                end

                DATA: begin
                    bus.mac_tx_en <= 1'b1;
                    if (bus.s_valid) begin
                        bus.mac_txd <= bus.s_data;
                        crc         <= crc_next(crc, bus.s_data);
                        byte_cnt    <= byte_cnt_inc;
                        if (bus.s_last) begin
                            if (short_frame) begin
                                state <= PAD;
                            end else begin
                                state <= FCS;
                                timer <= 8'd3;
                            end
                        end
                    end else begin
                        // s_last always leaves DATA, so an underrun here is mid-frame
                        bus.mac_tx_er <= 1'b1;
                        bus.underrun  <= 1'b1;
                        state         <= DROP;
                    end
                end

                PAD: begin
                    bus.mac_tx_en <= 1'b1;
                    crc           <= crc_next(crc, 8'h00);
                    byte_cnt      <= byte_cnt_inc;
                    if (!short_frame) begin
                        state <= FCS;
                        timer <= 8'd3;
                    end
                end

                FCS: begin
                    // Shifting in ones leaves the CRC at its init value after the last byte
                    bus.mac_txd   <= ~crc[7:0];
                    bus.mac_tx_en <= 1'b1;
                    crc           <= {8'hFF, crc[31:8]};
                    if (timer == 8'd0) begin
                        bus.frame_done <= 1'b1;
                        state          <= IFG;
                        timer          <= 8'(IFG_BYTES - 1);
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end

                DROP: begin
                    if (bus.s_valid && bus.s_last) begin
                        state <= IFG;
                        timer <= 8'(IFG_BYTES - 1);
                    end
                end

                IFG: begin
                    if (timer == 8'd0) state <= IDLE;
                    else               timer <= timer - 8'd1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_sequencer.sv
// Directed bench for gmii_tx_sequencer: one instance without padding, one with
// MIN_PAYLOAD=60; a selector routes the stimulus and observation to one of them.
module tb_gmii_tx_sequencer;

    localparam int PRE = 7;
    localparam int IFG = 12;

    logic clk;
    logic reset;
    int   sel;

    logic [7:0] tb_data;
    logic       tb_valid;
    logic       tb_last;

    gmii_tx_sequencer_if b0();
    gmii_tx_sequencer_if b60();

    gmii_tx_sequencer #(.PREAMBLE_LEN(PRE), .MIN_PAYLOAD(0), .IFG_BYTES(IFG)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    gmii_tx_sequencer #(.PREAMBLE_LEN(PRE), .MIN_PAYLOAD(60), .IFG_BYTES(IFG)) dut60 (
        .clk   (clk),
        .reset (reset),
        .bus   (b60)
    );

    assign b0.s_data   = tb_data;
    assign b0.s_last   = tb_last;
    assign b0.s_valid  = tb_valid && (sel == 0);
    assign b60.s_data  = tb_data;
    assign b60.s_last  = tb_last;
    assign b60.s_valid = tb_valid && (sel == 1);

    logic [7:0] v_txd;
    logic       v_en, v_er, v_ready, v_busy, v_fd, v_ur;
    assign v_txd   = (sel == 1) ? b60.mac_txd    : b0.mac_txd;
    assign v_en    = (sel == 1) ? b60.mac_tx_en  : b0.mac_tx_en;
    assign v_er    = (sel == 1) ? b60.mac_tx_er  : b0.mac_tx_er;
    assign v_ready = (sel == 1) ? b60.s_ready    : b0.s_ready;
    assign v_busy  = (sel == 1) ? b60.busy       : b0.busy;
    assign v_fd    = (sel == 1) ? b60.frame_done : b0.frame_done;
    assign v_ur    = (sel == 1) ? b60.underrun   : b0.underrun;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    int         gap_q[$];
    int         en_cycles, low_run, fd_cnt, ur_cnt, er_cnt, ur_with_er;
    logic [7:0] fd_byte, er_txd;

    function automatic logic [31:0] ref_fcs(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[k]) begin
            c = c ^ {24'h0, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void build_expected(input int min_len);
        logic [7:0] d[$];
        logic [31:0] f;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        d = pay;
        while (d.size() < min_len) d.push_back(8'h00);
        foreach (d[k]) exp_q.push_back(d[k]);
        f = ref_fcs(d);
        for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        gap_q.delete();
        en_cycles = 0; low_run = 0; fd_cnt = 0; ur_cnt = 0; er_cnt = 0; ur_with_er = 0;
        fd_byte = 8'h00; er_txd = 8'hFF;
    endtask

    // Advance to the next falling edge and log what the selected DUT shows there.
    task automatic tick();
        @(negedge clk);
        if (v_en) begin
            tx_q.push_back(v_txd);
            en_cycles++;
            if (low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
        end else begin
            low_run++;
        end
        if (v_fd) begin fd_cnt++; fd_byte = v_txd; end
        if (v_ur) begin ur_cnt++; if (v_er) ur_with_er++; end
        if (v_er) begin er_cnt++; er_txd = v_txd; end
    endtask

    task automatic send(input int stall_at, input int stall_len, input bit rnd_stall, output bit ok);
        int idx, left, guard;
        bit consume;
        idx = 0; left = stall_len; guard = 0;
        while (idx < pay.size() && guard < 6000) begin
            guard++;
            tb_data = pay[idx];
            tb_last = (idx == pay.size() - 1);
            if (idx == stall_at && left > 0) begin
                tb_valid = 1'b0;
                left--;
            end else if (rnd_stall && !v_ready) begin
                tb_valid = ($urandom_range(0, 1) == 1);
            end else begin
                tb_valid = 1'b1;
            end
            consume = tb_valid && v_ready;
            tick();
            if (consume) idx++;
        end
        ok = (idx == pay.size());
    endtask

    task automatic wait_idle(input string name);
        int guard;
        tb_valid = 1'b0;
        tb_last  = 1'b0;
        guard = 0;
        do begin
            tick();
            guard++;
        end while ((v_busy || v_en) && guard < 3000);
        checks++;
        if (v_busy || v_en) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b en=%0b after %0d cycles, required idle", name, v_busy, v_en, guard);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tb_valid = 1'b0; tb_last = 1'b0; tb_data = 8'h00; sel = 0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++; if (v_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %0h required 00", v_txd); end
            checks++; if (v_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %0b required 0", v_en); end
            checks++; if (v_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %0b required 0", v_er); end
            checks++; if (v_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b required 0", v_ready); end
            checks++; if (v_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", v_busy); end
            checks++; if (v_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b required 0", v_fd); end
            checks++; if (v_ur !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %0b required 0", v_ur); end
        end
        sel = 0;
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_crc_vector();
        logic [7:0] fcs_k [4];
        bit ok;
        fcs_k = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        sel = 0;
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs_k[i]);
        clear_mon();
        send(-1, 0, 1'b0, ok);
        wait_idle("crc_vector");
        checks++; if (!ok) begin errors++; $display("FAIL crc_vector_accept: payload not fully accepted"); end
        checks++; if (en_cycles !== 21) begin errors++; $display("FAIL crc_vector_en_cycles: got %0d required 21", en_cycles); end
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL crc_vector_byte%0d: got %0h required %0h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (fd_cnt !== 1 || fd_byte !== 8'hCB) begin errors++; $display("FAIL crc_vector_frame_done: count %0d on byte %0h, required 1 on CB", fd_cnt, fd_byte); end
        checks++; if (er_cnt !== 0) begin errors++; $display("FAIL crc_vector_tx_er: got %0d error cycles required 0", er_cnt); end
    endtask

    task automatic test_padding();
        bit ok;
        sel = 1;
        pay.delete();
        for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
        build_expected(60);
        clear_mon();
        send(-1, 0, 1'b0, ok);
        wait_idle("padding");
        checks++; if (en_cycles !== 72) begin errors++; $display("FAIL padding_en_cycles: got %0d required 72", en_cycles); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL padding_byte%0d: got %0h required %0h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (fd_cnt !== 1 || fd_byte !== exp_q[71]) begin errors++; $display("FAIL padding_frame_done: count %0d on byte %0h, required 1 on %0h", fd_cnt, fd_byte, exp_q[71]); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        sel = 0;
        pay.delete();
        pay.push_back(8'h41); pay.push_back(8'h42); pay.push_back(8'h43);
        clear_mon();
        send(-1, 0, 1'b0, ok1);
        send(-1, 0, 1'b0, ok2);
        wait_idle("back_to_back");
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_accept: frames accepted %0b/%0b required 1/1", ok1, ok2); end
        checks++; if (gap_q.size() !== 2) begin errors++; $display("FAIL b2b_gap_count: got %0d tx_en rises required 2", gap_q.size()); end
        else begin
            checks++; if (gap_q[1] !== IFG + 1) begin errors++; $display("FAIL b2b_gap_len: got %0d idle cycles required %0d", gap_q[1], IFG + 1); end
        end
        checks++; if (en_cycles !== 30) begin errors++; $display("FAIL b2b_en_cycles: got %0d required 30", en_cycles); end
        checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL b2b_frame_done: got %0d required 2", fd_cnt); end
        checks++; if (tx_q.size() < 16 || tx_q[15] !== 8'h55) begin errors++; $display("FAIL b2b_second_preamble: second frame does not start with 55"); end
    endtask

    task automatic test_underrun();
        bit ok;
        sel = 1;
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(8'hA0 + 8'(i));
        clear_mon();
        send(5, 20, 1'b0, ok);
        wait_idle("underrun");
        checks++; if (!ok) begin errors++; $display("FAIL underrun_drain: remaining bytes not consumed"); end
        checks++; if (er_cnt !== 1) begin errors++; $display("FAIL underrun_tx_er_cycles: got %0d required 1", er_cnt); end
        checks++; if (ur_cnt !== 1 || ur_with_er !== 1) begin errors++; $display("FAIL underrun_pulse: got %0d pulses (%0d with tx_er) required 1", ur_cnt, ur_with_er); end
        checks++; if (er_txd !== 8'h00) begin errors++; $display("FAIL underrun_txd: got %0h required 00", er_txd); end
        checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL underrun_frame_done: got %0d required 0", fd_cnt); end
        checks++; if (tx_q.size() !== 14) begin errors++; $display("FAIL underrun_en_cycles: got %0d required 14", tx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (8 + i >= tx_q.size() || tx_q[8 + i] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL underrun_byte%0d: wrong byte before abort, required %0h", i, 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_preamble();
        int n55, guard, lead;
        bit ok;
        sel = 0;
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        clear_mon();
        tb_data = pay[0]; tb_last = 1'b0; tb_valid = 1'b1;
        n55 = 0; guard = 0;
        while (n55 < 3 && guard < 50) begin
            tick();
            guard++;
            if (v_en && v_txd == 8'h55) n55++;
        end
        checks++; if (n55 !== 3) begin errors++; $display("FAIL rstpre_preamble_start: saw %0d preamble bytes required 3", n55); end
        reset = 1'b1;
        tick();
        checks++; if (v_en !== 1'b0) begin errors++; $display("FAIL rstpre_tx_en: got %0b required 0", v_en); end
        checks++; if (v_busy !== 1'b0) begin errors++; $display("FAIL rstpre_busy: got %0b required 0", v_busy); end
        checks++; if (v_ready !== 1'b0) begin errors++; $display("FAIL rstpre_s_ready: got %0b required 0", v_ready); end
        checks++; if (v_er !== 1'b0) begin errors++; $display("FAIL rstpre_tx_er: got %0b required 0", v_er); end
        reset = 1'b0;
        tb_valid = 1'b0;
        tick();
        clear_mon();
        send(-1, 0, 1'b0, ok);
        wait_idle("reset_preamble");
        lead = 0;
        while (lead < tx_q.size() && tx_q[lead] == 8'h55) lead++;
        checks++; if (lead !== 7) begin errors++; $display("FAIL rstpre_full_preamble: got %0d bytes of 55 required 7", lead); end
        checks++; if (en_cycles !== 21 || fd_cnt !== 1) begin errors++; $display("FAIL rstpre_frame: %0d en cycles %0d frame_done, required 21 and 1", en_cycles, fd_cnt); end
    endtask

    task automatic test_random();
        int lens [5];
        bit ok;
        int bad;
        lens = '{1, 59, 60, 61, 0};
        lens[4] = $urandom_range(62, 1518);
        sel = 1;
        for (int f = 0; f < 5; f++) begin
            pay.delete();
            for (int i = 0; i < lens[f]; i++) pay.push_back(8'($urandom_range(0, 255)));
            build_expected(60);
            clear_mon();
            send(-1, 0, 1'b1, ok);
            wait_idle("random");
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad++;
            end
            checks++; if (en_cycles !== exp_q.size()) begin errors++; $display("FAIL random_len%0d_en_cycles: got %0d required %0d", lens[f], en_cycles, exp_q.size()); end
            checks++; if (bad !== 0) begin errors++; $display("FAIL random_len%0d_bytes: got %0d wrong bytes required 0", lens[f], bad); end
            checks++; if (fd_cnt !== 1 || er_cnt !== 0 || !ok) begin errors++; $display("FAIL random_len%0d_status: frame_done %0d tx_er %0d accepted %0b, required 1 0 1", lens[f], fd_cnt, er_cnt, ok); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_crc_vector();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_reset_preamble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
